// File: rtl/sm_result_buffer.sv
// sm_result_buffer: show-ahead FIFO of {error, sm_number} results from u2_to_sm, plus sticky error and occupancy status.
// Latency: an accepted push is visible on out_valid/out_data one cycle later; the head is read combinationally from storage.
// Backpressure: in_ready drops while the FIFO holds DEPTH entries, and a pop on that edge does not let a push through.
// Optional build macro SM_BUF_ERR_DROP_EN: errored results are handshaked but not stored, and drop_cnt counts them.
module sm_result_buffer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               sm_number,
  input  logic                       error,
  input  logic                       rd_en,
  output logic [N-1:0]               out_data,
  output logic                       out_error,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_sticky,
  input  logic                       err_clr
`ifdef SM_BUF_ERR_DROP_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Each entry keeps the error flag in the MSB above the untouched result.
  logic [N:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic push_acc;    // handshake completed this edge
  logic push_store;  // handshake that actually writes an entry
  logic pop;
  logic [N:0] head;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign push_acc  = in_valid && in_ready;
  assign pop       = rd_en && out_valid;

`ifdef SM_BUF_ERR_DROP_EN
  assign push_store = push_acc && !error;
`else
  assign push_store = push_acc;
`endif

  // Show-ahead head, forced to zero while empty so stale storage never leaks out.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem[rd_ptr];
    end
  end

  assign out_data  = head[N-1:0];
  assign out_error = head[N];

  // Storage is not reset: entries only become visible through count, which is.
  always_ff @(posedge pclk) begin
    if (push_store) begin
      mem[wr_ptr] <= {error, sm_number};
    end
  end

  // Write and read pointers, each wrapping from DEPTH-1 back to 0.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_store) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy: simultaneous store and pop cancel; bounds hold because pop needs non-empty and store needs not-full.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      count_q <= '0;
    end else begin
      case ({push_store, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error: an errored handshake on the same edge as a clear keeps the bit set.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      err_sticky <= 1'b0;
    end else if (push_acc && error) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef SM_BUF_ERR_DROP_EN
  // Dropped-result counter: saturates at 8'hFF, and a clear beats an increment.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      drop_cnt <= 8'h00;
    end else if (err_clr) begin
      drop_cnt <= 8'h00;
    end else if (push_acc && error && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end
`endif

endmodule
